// File: rtl/wb_ssp_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_ssp_responder_pkg
// Description : Shared constants for the Wishbone-to-SSP responder: register
//               offsets, FSM state encoding, STATUS/CTRL bit positions and a
//               STATUS word packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ssp_responder_pkg;

    // Register offsets inside the four-word window
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // FSM state encoding
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_TX_WAIT = 4'd2;
    localparam logic [3:0] ST_SSP_WR  = 4'd3;
    localparam logic [3:0] ST_SSP_RD  = 4'd4;
    localparam logic [3:0] ST_RD_CAP  = 4'd5;
    localparam logic [3:0] ST_REG     = 4'd6;
    localparam logic [3:0] ST_TERM    = 4'd7;
    localparam logic [3:0] ST_HOLD    = 4'd8;

    // STATUS bit indices
    localparam int STAT_TXINTR   = 0;
    localparam int STAT_RXINTR   = 1;
    localparam int STAT_TX_TMO   = 2;
    localparam int STAT_RX_UFLOW = 3;

    // CTRL bit indices
    localparam int CTRL_TXIE = 0;
    localparam int CTRL_RXIE = 1;

    // Pack the STATUS register word from its four source bits
    function automatic logic [31:0] status_word(input logic rx_uflow, input logic tx_tmo,
                                                input logic rxintr, input logic txintr);
        logic [31:0] w;
        w = '0;
        w[STAT_RX_UFLOW] = rx_uflow;
        w[STAT_TX_TMO]   = tx_tmo;
        w[STAT_RXINTR]   = rxintr;
        w[STAT_TXINTR]   = txintr;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ssp_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_ssp_responder_if
// Description : Bundles the Wishbone master pins and the SSP peripheral port
//               seen by the responder. slave = responder, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_ssp_responder_if;
    logic [25:0] adr_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic        stb_i;
    logic        cyc_i;
    logic        tagn_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        tagn_o;
    logic        ssp_psel_o;
    logic        ssp_pwrite_o;
    logic [7:0]  ssp_pwdata_o;
    logic [7:0]  ssp_prdata_i;
    logic        ssp_txintr_i;
    logic        ssp_rxintr_i;
    logic        irq_o;

    modport slave (
        input  adr_i, dat_i, we_i, stb_i, cyc_i, tagn_i,
        input  ssp_prdata_i, ssp_txintr_i, ssp_rxintr_i,
        output dat_o, ack_o, err_o, tagn_o,
        output ssp_psel_o, ssp_pwrite_o, ssp_pwdata_o, irq_o
    );

    modport master (
        output adr_i, dat_i, we_i, stb_i, cyc_i, tagn_i,
        output ssp_prdata_i, ssp_txintr_i, ssp_rxintr_i,
        input  dat_o, ack_o, err_o, tagn_o,
        input  ssp_psel_o, ssp_pwrite_o, ssp_pwdata_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_resp_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_resp_timeout
// Description : Stall counter for TXDATA writes. load clears it, count_en
//               advances it, expire flags the WAIT_TIMEOUT-th counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_resp_timeout #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expire
);
    localparam int                 CNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WAIT_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Expire on the stall cycle that would bring the count to WAIT_TIMEOUT
    assign expire = count_en && (count == LAST);

    // Count stalled cycles; cleared on load or reset, saturates at expiry
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (count_en && !expire) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_ssp_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_ssp_responder
// Description : Wishbone responder for the four-word SSP register window.
//               Converts bus accesses into single-cycle PSEL strobes, returns
//               PRDATA/STATUS/CTRL and terminates with ack or err.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ssp_responder
    import wb_ssp_responder_pkg::*;
#(
    parameter logic [25:0] BASE_ADDR    = 26'h0010000,
    parameter int          WAIT_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_ssp_responder_if.slave     bus
);
    logic [3:0]  state;
    logic [1:0]  off;
    logic        we;
    logic [7:0]  wbyte;
    logic [31:0] dat_q;
    logic        ack_q;
    logic        err_q;
    logic        tagn_q;
    logic        psel_q;
    logic        pwrite_q;
    logic [7:0]  pwdata_q;
    logic [1:0]  ctrl;
    logic        tx_tmo;
    logic        rx_uflow;

    logic        hit;
    logic        tmr_load;
    logic        tmr_en;
    logic        tmr_expire;
    logic        tmo_set;
    logic        uflow_set;
    logic        status_clr;

    assign hit = bus.cyc_i && bus.stb_i && (bus.adr_i[25:2] == BASE_ADDR[25:2]);

    assign tmr_load   = (state == ST_DECODE);
    assign tmr_en     = (state == ST_TX_WAIT) && bus.ssp_txintr_i;
    assign tmo_set    = tmr_en && tmr_expire;
    assign uflow_set  = (state == ST_SSP_RD) && !psel_q && !bus.ssp_rxintr_i;
    assign status_clr = (state == ST_REG) && (off == OFF_STATUS) && !we;

    wb_resp_timeout #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (tmr_load),
        .count_en (tmr_en),
        .expire   (tmr_expire)
    );

    // Sticky STATUS flags: clear-on-read, a same-cycle set takes priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_tmo   <= 1'b0;
            rx_uflow <= 1'b0;
        end else begin
            tx_tmo   <= tmo_set   || (tx_tmo   && !status_clr);
            rx_uflow <= uflow_set || (rx_uflow && !status_clr);
        end
    end

    // Transfer FSM with registered bus and SSP outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            off      <= '0;
            we       <= 1'b0;
            wbyte    <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            tagn_q   <= 1'b0;
            psel_q   <= 1'b0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            ctrl     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        off    <= bus.adr_i[1:0];
                        we     <= bus.we_i;
                        wbyte  <= bus.dat_i[7:0];
                        tagn_q <= bus.tagn_i;
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (off == OFF_TXDATA && we) begin
                        state <= ST_TX_WAIT;
                    end else if (off == OFF_RXDATA && !we) begin
                        state <= ST_SSP_RD;
                    end else begin
                        state <= ST_REG;
                    end
                end
                ST_TX_WAIT: begin
                    if (!bus.ssp_txintr_i) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        pwdata_q <= wbyte;
                        state    <= ST_SSP_WR;
                    end else if (tmr_expire) begin
                        err_q <= 1'b1;
                        state <= ST_TERM;
                    end
                end
                ST_SSP_WR: begin
                    psel_q   <= 1'b0;
                    pwrite_q <= 1'b0;
                    ack_q    <= 1'b1;
                    state    <= ST_TERM;
                end
                ST_SSP_RD: begin
                    // First cycle checks the RX FIFO, second cycle carries the strobe
                    if (psel_q) begin
                        psel_q <= 1'b0;
                        state  <= ST_RD_CAP;
                    end else if (bus.ssp_rxintr_i) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b0;
                    end else begin
                        dat_q <= '0;
                        ack_q <= 1'b1;
                        state <= ST_TERM;
                    end
                end
                ST_RD_CAP: begin
                    dat_q <= {24'b0, bus.ssp_prdata_i};
                    ack_q <= 1'b1;
                    state <= ST_TERM;
                end
                ST_REG: begin
                    state <= ST_TERM;
                    if (off == OFF_STATUS && !we) begin
                        dat_q <= status_word(rx_uflow, tx_tmo, bus.ssp_rxintr_i, bus.ssp_txintr_i);
                        ack_q <= 1'b1;
                    end else if (off == OFF_CTRL) begin
                        if (we) begin
                            ctrl <= wbyte[1:0];
                        end else begin
                            dat_q <= {30'b0, ctrl};
                        end
                        ack_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ST_TERM: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    dat_q <= '0;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Wait for the master to drop stb so one cycle is acked once
                    if (!bus.stb_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dat_o        = dat_q;
    assign bus.ack_o        = ack_q;
    assign bus.err_o        = err_q;
    assign bus.tagn_o       = tagn_q;
    assign bus.ssp_psel_o   = psel_q;
    assign bus.ssp_pwrite_o = pwrite_q;
    assign bus.ssp_pwdata_o = pwdata_q;
    assign bus.irq_o        = (ctrl[CTRL_TXIE] && !bus.ssp_txintr_i) ||
                              (ctrl[CTRL_RXIE] &&  bus.ssp_rxintr_i);
endmodule
`default_nettype wire

// File: tb/tb_wb_ssp_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ssp_responder
// Description : Self-checking bench: transaction-level reference model with
//               per-cycle output comparison, directed cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ssp_responder;
    import wb_ssp_responder_pkg::*;

    localparam logic [25:0] BASE = 26'h0010000;
    localparam int          TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [1:0] m_ctrl  = 2'b00;
    logic       m_tmo   = 1'b0;
    logic       m_uflow = 1'b0;

    logic [31:0] rdat;
    int          tk;

    always #5 clk = ~clk;

    wb_ssp_responder_if bus();

    wb_ssp_responder #(
        .BASE_ADDR    (BASE),
        .WAIT_TIMEOUT (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One bus access; expectations come from the register-window rules.
    // stall = number of stalled TX cycles, txlvl/rx = FIFO levels otherwise.
    task automatic xfer(input logic [25:0] adr, input logic wr, input logic [31:0] wdat,
                        input logic tag, input int stall, input logic txlvl, input logic rx,
                        input logic [7:0] prd, input bit early,
                        output logic [31:0] seen, output int termk);
        bit         hit, is_tx, exp_ack, exp_err, ctrl_wr, set_tmo, set_uf, clr, hold;
        logic [1:0] off, nctrl, cur_ctrl;
        logic [31:0] edat;
        logic       tx_now, exp_irq;
        int         t, pk, last;
        hit = (adr[25:2] == BASE[25:2]);
        off = adr[1:0];
        is_tx = hit && off == OFF_TXDATA && wr;
        exp_ack = 0; exp_err = 0; ctrl_wr = 0; set_tmo = 0; set_uf = 0; clr = 0;
        nctrl = m_ctrl; edat = '0; t = -1; pk = -1;
        if (!hit) begin
            last = 5;
        end else begin
            if (is_tx) begin
                if (stall >= TMO) begin t = 2 + TMO; exp_err = 1; set_tmo = 1; end
                else begin pk = 3 + stall; t = 4 + stall; exp_ack = 1; end
            end else if (off == OFF_RXDATA && !wr) begin
                exp_ack = 1;
                if (rx) begin pk = 3; t = 5; edat = {24'b0, prd}; end
                else begin t = 3; set_uf = 1; end
            end else if (off == OFF_STATUS && !wr) begin
                t = 3; exp_ack = 1; clr = 1;
                edat = {28'b0, m_uflow, m_tmo, rx, txlvl};
            end else if (off == OFF_CTRL) begin
                t = 3; exp_ack = 1;
                if (wr) begin ctrl_wr = 1; nctrl = wdat[1:0]; end
                else edat = {30'b0, m_ctrl};
            end else begin
                t = 3; exp_err = 1;
            end
            last = t + 1;
        end
        seen = '0;
        termk = -1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            if (!hit) hold = (k < 4);
            else      hold = early ? (k == 0) : (k <= t);
            bus.cyc_i  = hold;
            bus.stb_i  = hold;
            bus.adr_i  = adr;
            bus.we_i   = wr;
            bus.dat_i  = wdat;
            bus.tagn_i = tag;
            tx_now = is_tx ? (k < 2 + stall) : txlvl;
            bus.ssp_txintr_i = tx_now;
            bus.ssp_rxintr_i = rx;
            bus.ssp_prdata_i = (k == 4) ? prd : ~prd;
            @(negedge clk);
            cur_ctrl = (ctrl_wr && k >= t) ? nctrl : m_ctrl;
            exp_irq  = (cur_ctrl[0] & ~tx_now) | (cur_ctrl[1] & rx);
            if ((bus.ack_o || bus.err_o) && termk < 0) termk = k;
            check("ack",  32'(bus.ack_o),      32'(exp_ack && k == t));
            check("err",  32'(bus.err_o),      32'(exp_err && k == t));
            check("psel", 32'(bus.ssp_psel_o), 32'(k == pk));
            check("irq",  32'(bus.irq_o),      32'(exp_irq));
            if (k == pk) begin
                check("pwrite", 32'(bus.ssp_pwrite_o), 32'(wr));
                if (wr) check("pwdata", 32'(bus.ssp_pwdata_o), {24'b0, wdat[7:0]});
            end
            if (k == t) begin
                check("tagn", 32'(bus.tagn_o), 32'(tag));
                seen = bus.dat_o;
                if (exp_ack && !wr) check("dat_o", bus.dat_o, edat);
            end
        end
        m_ctrl = nctrl;
        if (clr)     begin m_tmo = 1'b0; m_uflow = 1'b0; end
        if (set_tmo) m_tmo = 1'b1;
        if (set_uf)  m_uflow = 1'b1;
    endtask

    initial begin
        bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
        bus.tagn_i = 1'b0; bus.ssp_prdata_i = '0; bus.ssp_txintr_i = 1'b0; bus.ssp_rxintr_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack",    32'(bus.ack_o),        32'd0);
        check("rst_err",    32'(bus.err_o),        32'd0);
        check("rst_psel",   32'(bus.ssp_psel_o),   32'd0);
        check("rst_pwrite", 32'(bus.ssp_pwrite_o), 32'd0);
        check("rst_pwdata", 32'(bus.ssp_pwdata_o), 32'd0);
        check("rst_dat",    bus.dat_o,             32'd0);
        check("rst_tagn",   32'(bus.tagn_o),       32'd0);
        check("rst_irq",    32'(bus.irq_o),        32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // TXDATA write, no stall
        xfer(BASE, 1'b1, 32'h000000A5, 1'b1, 0, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("tx_latency", 32'(tk), 32'd4);
        check("tx_pwdata_lit", 32'(bus.ssp_pwdata_o), 32'h000000A5);

        // RXDATA read with data available
        xfer(BASE + 26'd1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1, 8'h3C, 0, rdat, tk);
        check("rx_data_lit", rdat, 32'h0000003C);
        check("rx_latency", 32'(tk), 32'd5);

        // RX underflow then STATUS clear-on-read
        xfer(BASE + 26'd1, 1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 8'h77, 0, rdat, tk);
        check("uflow_data_lit", rdat, 32'h0);
        xfer(BASE + 26'd2, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("status_uflow_lit", rdat, 32'h00000008);
        check("status_latency", 32'(tk), 32'd3);
        xfer(BASE + 26'd2, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("status_cleared_lit", rdat, 32'h00000000);

        // TX timeout
        xfer(BASE, 1'b1, 32'h11, 1'b1, 20, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("tmo_latency", 32'(tk), 32'(2 + TMO));
        xfer(BASE + 26'd2, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("status_tmo_lit", rdat, 32'h00000004);

        // CTRL write and interrupt
        xfer(BASE + 26'd3, 1'b1, 32'h00000002, 1'b0, 0, 1'b0, 1'b1, 8'h00, 0, rdat, tk);
        check("irq_rxie_lit", 32'(bus.irq_o), 32'd1);
        xfer(BASE + 26'd3, 1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b1, 8'h00, 0, rdat, tk);
        check("ctrl_read_lit", rdat, 32'h00000002);

        // Write to read-only STATUS, out-of-window access
        xfer(BASE + 26'd2, 1'b1, 32'hFFFF, 1'b1, 0, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("ro_err_latency", 32'(tk), 32'd3);
        xfer(26'h0020000, 1'b1, 32'h1234, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0, rdat, tk);
        check("miss_no_term", 32'(tk), 32'hFFFFFFFF);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [25:0] a;
            int          st, sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 85) begin
                a = BASE + 26'($urandom_range(0, 3));
            end else begin
                a = 26'($urandom);
                if (a[25:2] == BASE[25:2]) a[20] = ~a[20];
            end
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      st = int'($urandom_range(0, 5));
            else if (sel < 85) st = int'($urandom_range(6, TMO - 1));
            else               st = int'($urandom_range(TMO, TMO + 4));
            xfer(a, 1'($urandom), $urandom, 1'($urandom), st, 1'($urandom), 1'($urandom),
                 8'($urandom), ($urandom_range(0, 7) == 0), rdat, tk);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset asserted while stalled in TX_WAIT
        xfer(BASE + 26'd3, 1'b1, 32'h3, 1'b0, 0, 1'b1, 1'b1, 8'h00, 0, rdat, tk);
        for (int k = 0; k < 26; k++) begin
            @(posedge clk); #1;
            bus.cyc_i = (k < 4);
            bus.stb_i = (k < 4);
            bus.adr_i = BASE;
            bus.we_i  = 1'b1;
            bus.dat_i = 32'h5A;
            bus.tagn_i = 1'b1;
            bus.ssp_txintr_i = 1'b1;
            bus.ssp_rxintr_i = 1'b1;
            rst = (k == 4);
            @(negedge clk);
            if (k == 5) begin
                check("mid_rst_dat",    bus.dat_o,             32'd0);
                check("mid_rst_tagn",   32'(bus.tagn_o),       32'd0);
                check("mid_rst_pwrite", 32'(bus.ssp_pwrite_o), 32'd0);
                check("mid_rst_pwdata", 32'(bus.ssp_pwdata_o), 32'd0);
                check("mid_rst_irq",    32'(bus.irq_o),        32'd0);
            end
            if (k >= 5) begin
                check("mid_rst_ack",  32'(bus.ack_o),      32'd0);
                check("mid_rst_err",  32'(bus.err_o),      32'd0);
                check("mid_rst_psel", 32'(bus.ssp_psel_o), 32'd0);
            end
        end
        m_ctrl = 2'b00; m_tmo = 1'b0; m_uflow = 1'b0;
        xfer(BASE + 26'd2, 1'b0, 32'h0, 1'b0, 0, 1'b1, 1'b0, 8'h00, 0, rdat, tk);
        check("post_rst_status_lit", rdat, 32'h00000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
